// File: rtl/muldiv_unit_pkg.sv
// Shared encode definitions for the multiply/divide unit and the controller side that drives it.
// Holds the 2-bit operation codes, the unit's state codes, the controller funct constants for
// the HI/LO instruction group, and small op-decode helpers.
package muldiv_unit_pkg;

  // Operation codes presented on muldiv_unit.op
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // State codes
  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_ITER = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = MD_IDLE,
    StIter = MD_ITER,
    StFix  = MD_FIX,
    StDone = MD_DONE
  } md_state_e;

  // Controller-side R-type funct fields for the HI/LO group
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  // op[1] selects divide, op[0] selects the unsigned variant
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide, both on sign magnitudes,
// with the sign applied in a single FIX cycle.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start, op, a, b   launch an operation (sampled only in IDLE)
//   hi_we, lo_we      mthi/mtlo strobes with data on wdata (honoured in IDLE/DONE only)
//   busy              operation in progress (ITER and FIX)
//   done              one-cycle pulse once HI/LO hold the new result
//   dz                divide-by-zero flag, held until the next accepted start
//   hi, lo            HI/LO registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  md_state_e          state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign_quo_q, sign_quo_d;  // a[MSB] ^ b[MSB]
  logic               sign_rem_q, sign_rem_d;  // a[MSB]
  logic               bzero_q, bzero_d;
  logic               dz_q, dz_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;            // product, or remainder:quotient
  logic [WIDTH-1:0]   opnd_q, opnd_d;          // |multiplicand| or |divisor|
  logic [WIDTH-1:0]   a_q, a_d;                // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand magnitudes at issue time
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = md_is_signed(op) & a[WIDTH-1];
    b_neg = md_is_signed(op) & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  // One multiply step: conditional add into the upper half, then shift right with the carry.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // One restoring-divide step on the left-shifted remainder (WIDTH+1 bits wide).
  logic [WIDTH:0]     rem_ext;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    rem_ext  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_ext - {1'b0, opnd_q};
    div_ok   = ~div_diff[WIDTH];
    div_next = div_ok ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                      : {acc_q[2*WIDTH-2:0], 1'b0};
  end

  // Sign fix-up of the finished magnitudes
  logic               fix_signed;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    fix_signed = md_is_signed(op_q);
    prod_fix   = (fix_signed & sign_quo_q) ? (~acc_q + 1'b1) : acc_q;
    quo_fix    = (fix_signed & sign_quo_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix    = (fix_signed & sign_rem_q) ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                           : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    bzero_d    = bzero_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_d        = a_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // start wins over a same-cycle mthi/mtlo
          op_d       = op;
          sign_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
          sign_rem_d = a[WIDTH-1];
          bzero_d    = (b == '0);
          dz_d       = 1'b0;
          a_d        = a;
          cnt_d      = CntW'(WIDTH);
          acc_d      = md_is_div(op) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          opnd_d     = md_is_div(op) ? b_mag : a_mag;
          state_d    = StIter;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      StIter: begin
        acc_d = md_is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        if (!md_is_div(op_q)) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (bzero_q) begin
          hi_d = a_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = StDone;
      end
      StDone: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      bzero_q    <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      bzero_q    <= bzero_d;
      dz_q       <= dz_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_q        <= a_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q == StIter) || (state_q == StFix);
  assign done = (state_q == StDone);
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
